// File: rtl/bus_responder.sv
// ----------------------------------------------------------------------------
// bus_responder
//
// Memory-side end of the processor bus. Every rising edge the request on
// {address_bus, control_bus, wdata_bus} is decoded to one of three targets:
//   - word-addressed on-chip RAM at word addresses 0 .. 2**RAM_AW-1
//   - a 16-word MMIO window at MMIO_BASE (CYCLE, GPIO, TXDATA, STATUS)
//   - a TX byte FIFO, drained through a valid/ready stream port
// Read data is registered on rdata_bus and held until the next read.
//
// Optional feature macro: BUS_RESPONDER_TIMER_EN
//   defined   -> free-running 32-bit CYCLE counter at MMIO_BASE+0
//   undefined -> no counter flops; MMIO_BASE+0 behaves as a reserved word
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        synchronous, active-high reset
//   address_bus  word address from the processor
//   control_bus  {read, write} strobes; 2'b11 is illegal (acts as a write)
//   wdata_bus    write data
//   rdata_bus    registered read data
//   gpio_out     GPIO output register
//   tx_data      FIFO head byte (0 while the FIFO is empty)
//   tx_valid     FIFO non-empty
//   tx_ready     consumer accepts tx_data when high together with tx_valid
// ----------------------------------------------------------------------------
module bus_responder #(
    parameter int                ADDR_W     = 23,
    parameter int                DATA_W     = 32,
    parameter int                RAM_AW     = 12,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = 23'h7FFFF0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_bus,
    input  logic [1:0]        control_bus,
    input  logic [DATA_W-1:0] wdata_bus,
    output logic [DATA_W-1:0] rdata_bus,
    output logic [DATA_W-1:0] gpio_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OFF_CYCLE  = 4'd0;
    localparam logic [3:0] OFF_GPIO   = 4'd1;
    localparam logic [3:0] OFF_TXDATA = 4'd2;
    localparam logic [3:0] OFF_STATUS = 4'd3;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic       rd_req, wr_req, proto_bad;
    logic       in_ram, in_mmio, unmapped;
    logic [3:0] offset;

    assign rd_req    = (control_bus == 2'b10);
    assign wr_req    = control_bus[0];          // 2'b01 and illegal 2'b11
    assign proto_bad = (control_bus == 2'b11);

    assign in_ram   = (address_bus[ADDR_W-1:RAM_AW] == '0);
    assign in_mmio  = (address_bus[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
    assign unmapped = !in_ram && !in_mmio;
    assign offset   = address_bus[3:0];

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ram      [2**RAM_AW];
    logic [7:0]        fifo_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow, bus_err, proto_err;

    logic fifo_empty, fifo_full, push_req, push, pop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

    // Full is judged on the pre-edge count, so a push while full is dropped
    // even if a pop frees a slot on the same edge.
    assign push_req = wr_req && in_mmio && (offset == OFF_TXDATA);
    assign push     = push_req && !fifo_full;
    assign pop      = !fifo_empty && tx_ready;

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

    // ------------------------------------------------------------------
    // Optional cycle counter
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] cycle_rdata;

`ifdef BUS_RESPONDER_TIMER_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (reset) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + 32'd1;   // wraps naturally
    end

    assign cycle_rdata = DATA_W'(cycle_cnt);
`else
    assign cycle_rdata = '0;
`endif

    // ------------------------------------------------------------------
    // Read mux (pre-edge state; the register below captures it)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] status_word, mmio_rdata, read_data;

    // NOTE: every combinational output gets a default before the case/if
    // so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        status_word       = '0;
        status_word[0]    = fifo_empty;
        status_word[1]    = fifo_full;
        status_word[2]    = overflow;
        status_word[3]    = bus_err;
        status_word[4]    = proto_err;
        status_word[15:8] = 8'(count);
    end

    always_comb begin
        mmio_rdata = '0;
        case (offset)
            OFF_CYCLE:  mmio_rdata = cycle_rdata;
            OFF_GPIO:   mmio_rdata = gpio_out;
            OFF_STATUS: mmio_rdata = status_word;
            default:    mmio_rdata = '0;      // TXDATA and reserved words
        endcase
    end

    always_comb begin
        read_data = '0;
        if (in_ram)       read_data = ram[address_bus[RAM_AW-1:0]];
        else if (in_mmio) read_data = mmio_rdata;
    end

    // ------------------------------------------------------------------
    // Memories: write ports only, no reset
    // ------------------------------------------------------------------
    // NOTE: RAM and FIFO storage are deliberately left out of reset; the
    // pointers/count define which FIFO entries are meaningful, and RAM
    // contents must survive a reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_req && in_ram)
            ram[address_bus[RAM_AW-1:0]] <= wdata_bus;
        if (push)
            fifo_mem[wr_ptr] <= wdata_bus[7:0];
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [2:0] status_clr;

    assign status_clr = (wr_req && in_mmio && offset == OFF_STATUS) ?
                        wdata_bus[4:2] : 3'b000;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_bus <= '0;
            gpio_out  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            bus_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (rd_req)
                rdata_bus <= read_data;

            if (wr_req && in_mmio && offset == OFF_GPIO)
                gpio_out <= wdata_bus;

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Write-1-to-clear; a set on the same edge wins.
            overflow  <= (overflow  & ~status_clr[0]) | (push_req && fifo_full);
            bus_err   <= (bus_err   & ~status_clr[1]) | ((rd_req || wr_req) && unmapped);
            proto_err <= (proto_err & ~status_clr[2]) | proto_bad;
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// ----------------------------------------------------------------------------
// tb_bus_responder
//
// Self-checking bench for bus_responder. A behavioural model (associative
// array RAM, byte queue FIFO, plain sticky flags and an edge counter) tracks
// what the bus should return; directed scenarios plus a randomized run are
// compared against it and against fixed expected constants.
// ----------------------------------------------------------------------------
module tb_bus_responder;

    localparam int          ADDR_W = 23;
    localparam int          DATA_W = 32;
    localparam logic [22:0] MB     = 23'h7FFFF0;
    localparam logic [22:0] A_CYC  = MB + 23'd0;
    localparam logic [22:0] A_GPIO = MB + 23'd1;
    localparam logic [22:0] A_TX   = MB + 23'd2;
    localparam logic [22:0] A_STAT = MB + 23'd3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] address_bus = '0;
    logic [1:0]        control_bus = 2'b00;
    logic [DATA_W-1:0] wdata_bus = '0;
    logic [DATA_W-1:0] rdata_bus;
    logic [DATA_W-1:0] gpio_out;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    bus_responder dut (
        .clk         (clk),
        .reset       (reset),
        .address_bus (address_bus),
        .control_bus (control_bus),
        .wdata_bus   (wdata_bus),
        .rdata_bus   (rdata_bus),
        .gpio_out    (gpio_out),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] m_ram [int];
    logic [7:0]  m_q [$];
    logic [31:0] m_gpio  = 0;
    logic [31:0] m_rdata = 0;
    bit          m_known = 1;
    bit          m_ovf = 0, m_berr = 0, m_perr = 0;
    logic [31:0] m_cycle = 0;

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 0;
        s[0]    = (m_q.size() == 0);
        s[1]    = (m_q.size() == 8);
        s[2]    = m_ovf;
        s[3]    = m_berr;
        s[4]    = m_perr;
        s[15:8] = 8'(m_q.size());
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [22:0] a, output bit known);
        known = 1;
        if (a < 23'd4096) begin
            known = m_ram.exists(int'(a));
            return known ? m_ram[int'(a)] : 32'h0;
        end
        if (a >= MB) begin
            case (a - MB)
`ifdef BUS_RESPONDER_TIMER_EN
                0: return m_cycle;
`endif
                1: return m_gpio;
                3: return model_status();
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    // One bus cycle: drive, clock, advance the model. Outputs settle #1 later.
    task automatic bus_cycle(input logic [1:0] ctrl, input logic [22:0] a,
                             input logic [31:0] wd, input logic rdy);
        logic [31:0] rv;
        bit          known, full, do_pop, mapped;
        rv     = model_read(a, known);
        full   = (m_q.size() == 8);
        do_pop = (m_q.size() > 0) && rdy;
        mapped = (a < 23'd4096) || (a >= MB);
        control_bus = ctrl;
        address_bus = a;
        wdata_bus   = wd;
        tx_ready    = rdy;
        @(posedge clk);
        #1;
        if (ctrl == 2'b10) begin
            m_rdata = rv;
            m_known = known;
        end
        if (do_pop) void'(m_q.pop_front());
        if (ctrl[0]) begin
            if (a < 23'd4096) m_ram[int'(a)] = wd;
            if (a == A_GPIO) m_gpio = wd;
            if (a == A_TX) begin
                if (full) m_ovf = 1;
                else      m_q.push_back(wd[7:0]);
            end
            if (a == A_STAT) begin
                if (wd[2] && !(full && 0)) m_ovf = m_ovf && !(a == A_STAT && wd[2]);
                if (wd[3]) m_berr = 0;
                if (wd[4]) m_perr = 0;
            end
        end
        if (ctrl != 2'b00 && !mapped) m_berr = 1;
        if (ctrl == 2'b11) m_perr = 1;
        m_cycle = m_cycle + 32'd1;
        control_bus = 2'b00;
    endtask

    task automatic do_reset(input int n);
        control_bus = 2'b00;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset   = 1'b0;
        m_q.delete();
        m_gpio  = 0;
        m_rdata = 0;
        m_known = 1;
        m_ovf   = 0;
        m_berr  = 0;
        m_perr  = 0;
        m_cycle = 0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset(2);
        checks++;
        if (rdata_bus !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want %h", rdata_bus, 32'h0);
        end
        checks++;
        if (gpio_out !== 32'h0) begin
            errors++; $display("FAIL reset_gpio: got %h want %h", gpio_out, 32'h0);
        end
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx: got valid=%b data=%h want 0/00", tx_valid, tx_data);
        end
        bus_cycle(2'b10, A_STAT, 0, 0);
        checks++;
        if (rdata_bus !== 32'h0000_0001) begin
            errors++; $display("FAIL reset_status: got %h want %h", rdata_bus, 32'h1);
        end
    endtask

    task automatic test_cycle();
        logic [31:0] want;
`ifdef BUS_RESPONDER_TIMER_EN
        want = 32'd9;
`else
        want = 32'd0;
`endif
        do_reset(2);
        repeat (9) bus_cycle(2'b00, 0, 0, 0);
        bus_cycle(2'b10, A_CYC, 0, 0);
        checks++;
        if (rdata_bus !== want) begin
            errors++; $display("FAIL cycle_read: got %0d want %0d", rdata_bus, want);
        end
        bus_cycle(2'b01, A_CYC, 32'hFFFF_0000, 0);  // ignored write
        bus_cycle(2'b10, A_STAT, 0, 0);
        checks++;
        if (rdata_bus[3] !== 1'b0) begin
            errors++; $display("FAIL cycle_write_no_err: got bus_err=%b want 0", rdata_bus[3]);
        end
    endtask

    task automatic test_ram();
        bus_cycle(2'b01, 23'h005, 32'hDEAD_BEEF, 0);
        bus_cycle(2'b10, 23'h005, 0, 0);
        checks++;
        if (rdata_bus !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_read: got %h want %h", rdata_bus, 32'hDEADBEEF);
        end
        bus_cycle(2'b00, 0, 0, 0);
        bus_cycle(2'b00, 0, 0, 0);
        checks++;
        if (rdata_bus !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_hold: got %h want %h", rdata_bus, 32'hDEADBEEF);
        end
        bus_cycle(2'b01, 23'hFFF, 32'h0BAD_F00D, 0);
        bus_cycle(2'b10, 23'hFFF, 0, 0);
        checks++;
        if (rdata_bus !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL ram_top_word: got %h want %h", rdata_bus, 32'h0BADF00D);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [7:0] got [$];
        int         guard;
        for (int i = 0; i < 9; i++) bus_cycle(2'b01, A_TX, 32'h41 + i, 0);
        bus_cycle(2'b10, A_STAT, 0, 0);
        checks++;
        if (rdata_bus !== 32'h0000_0806) begin
            errors++; $display("FAIL fifo_full_status: got %h want %h", rdata_bus, 32'h806);
        end
        bus_cycle(2'b10, A_TX, 0, 0);
        checks++;
        if (rdata_bus !== 32'h0) begin
            errors++; $display("FAIL txdata_reads_zero: got %h want 0", rdata_bus);
        end
        guard = 0;
        while (tx_valid === 1'b1 && guard < 20) begin
            got.push_back(tx_data);
            bus_cycle(2'b00, 0, 0, 1);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++; $display("FAIL fifo_drain_timeout: got %0d pops want 8", guard);
        end
        checks++;
        if (got.size() != 8) begin
            errors++; $display("FAIL fifo_drain_count: got %0d want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== 8'(8'h41 + i)) begin
                    errors++; $display("FAIL fifo_order[%0d]: got %h want %h", i, got[i], 8'(8'h41 + i));
                end
            end
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_sticky();
        bus_cycle(2'b10, 23'h001000, 0, 0);
        checks++;
        if (rdata_bus !== 32'h0) begin
            errors++; $display("FAIL unmapped_read: got %h want 0", rdata_bus);
        end
        bus_cycle(2'b10, A_STAT, 0, 0);
        checks++;
        if (rdata_bus[3] !== 1'b1) begin
            errors++; $display("FAIL bus_err_set: got %b want 1", rdata_bus[3]);
        end
        bus_cycle(2'b11, 23'h010, 32'h1111_2222, 0);
        checks++;
        if (rdata_bus[3] !== 1'b1) begin
            errors++; $display("FAIL proto_rdata_hold: got %h want bit3 set (held)", rdata_bus);
        end
        bus_cycle(2'b10, A_STAT, 0, 0);
        checks++;
        if (rdata_bus[4] !== 1'b1) begin
            errors++; $display("FAIL proto_err_set: got %b want 1", rdata_bus[4]);
        end
        bus_cycle(2'b01, A_STAT, 32'h1C, 0);
        bus_cycle(2'b10, A_STAT, 0, 0);
        checks++;
        if (rdata_bus[4:2] !== 3'b000 || rdata_bus !== model_status()) begin
            errors++; $display("FAIL sticky_clear: got %h want %h", rdata_bus, model_status());
        end
        // Illegal strobe aimed at STATUS with a clear: the set wins.
        bus_cycle(2'b11, A_STAT, 32'h10, 0);
        bus_cycle(2'b10, A_STAT, 0, 0);
        checks++;
        if (rdata_bus[4] !== 1'b1) begin
            errors++; $display("FAIL set_wins: got proto_err=%b want 1", rdata_bus[4]);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) bus_cycle(2'b01, A_TX, 32'hA0 + i, 0);
        bus_cycle(2'b01, A_GPIO, 32'h1234_5678, 0);
        bus_cycle(2'b10, A_GPIO, 0, 0);
        do_reset(1);
        checks++;
        if (tx_valid !== 1'b0 || gpio_out !== 32'h0 || rdata_bus !== 32'h0) begin
            errors++; $display("FAIL reset_mid: got valid=%b gpio=%h rdata=%h want 0/0/0",
                               tx_valid, gpio_out, rdata_bus);
        end
        bus_cycle(2'b10, A_STAT, 0, 0);
        checks++;
        if (rdata_bus !== 32'h0000_0001) begin
            errors++; $display("FAIL reset_mid_status: got %h want %h", rdata_bus, 32'h1);
        end
        bus_cycle(2'b10, 23'h005, 0, 0);
        checks++;
        if (rdata_bus !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_survives_reset: got %h want %h", rdata_bus, 32'hDEADBEEF);
        end
    endtask

    task automatic test_push_pop();
        logic [7:0] got [$];
        logic [7:0] want [$];
        int         guard;
        for (int i = 0; i < 4; i++) begin
            bus_cycle(2'b01, A_TX, 32'hC0 + i, 0);
            want.push_back(8'(8'hC0 + i));
        end
        want.push_back(8'h55);
        got.push_back(tx_data);                  // byte popped on the push edge
        bus_cycle(2'b01, A_TX, 32'h55, 1);
        bus_cycle(2'b10, A_STAT, 0, 0);
        checks++;
        if (rdata_bus[15:8] !== 8'd4) begin
            errors++; $display("FAIL push_pop_count: got %0d want 4", rdata_bus[15:8]);
        end
        guard = 0;
        while (tx_valid === 1'b1 && guard < 20) begin
            got.push_back(tx_data);
            bus_cycle(2'b00, 0, 0, 1);
            guard++;
        end
        checks++;
        if (got != want) begin
            errors++; $display("FAIL push_pop_order: got %p want %p", got, want);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0]  ctrl;
        logic [22:0] a;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: ctrl = 2'b00;
                3, 4, 5: ctrl = 2'b01;
                9:       ctrl = 2'b11;
                default: ctrl = 2'b10;
            endcase
            case ($urandom_range(0, 6))
                0, 1:    a = 23'($urandom_range(0, 15));
                2:       a = ($urandom_range(0, 1) != 0) ? 23'h000FFF : 23'h001000;
                3:       a = MB + 23'($urandom_range(0, 15));
                4:       a = A_TX;
                5:       a = A_STAT;
                default: a = 23'h7FFFEF;
            endcase
            bus_cycle(ctrl, a, $urandom, 1'($urandom_range(0, 1)));
            checks++;
            if (m_known && rdata_bus !== m_rdata) begin
                errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, rdata_bus, m_rdata);
            end
            checks++;
            if (tx_valid !== (m_q.size() != 0) ||
                (m_q.size() != 0 && tx_data !== m_q[0])) begin
                errors++; $display("FAIL rand_tx[%0d]: got valid=%b data=%h want size=%0d",
                                   n, tx_valid, tx_data, m_q.size());
            end
            checks++;
            if (gpio_out !== m_gpio) begin
                errors++; $display("FAIL rand_gpio[%0d]: got %h want %h", n, gpio_out, m_gpio);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_ram();
        test_fifo_overflow();
        test_sticky();
        test_reset_mid();
        test_push_pop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
